// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: per-stage hold/flush/bubble,
// PC write enable, drain-then-halt sequencing and saturating stall/flush counters.
module pipeline_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [31:0]      inst_ID,
    input  logic             uses_rt_ID,
    input  logic [4:0]       rd_num_EX,
    input  logic [4:0]       rd_num_MEM,
    input  logic [4:0]       rd_num_WB,
    input  logic             we_EX,
    input  logic             we_MEM,
    input  logic             we_WB,
    input  logic             redirect_MEM,
    input  logic             mem_access_MEM,
    input  logic             cache_ready,
    output logic             pc_we,
    output logic             hold_ifid,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic             flush_exmem,
    output logic             freeze_all,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] DRAIN    = 2'd2;
    localparam logic [1:0] HALTED   = 2'd3;

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    logic [1:0]    state, next_state;
    logic [DW-1:0] drain_cnt, next_drain;
    logic          stall_inc, flush_inc;

    logic [4:0] rs, rt;
    logic       hit_rs, hit_rt, raw, syscall_ID, miss;

    assign rs = inst_ID[25:21];
    assign rt = inst_ID[20:16];

    // No write-through in the register file, so a WB producer still has to stall.
    assign hit_rs = (rs != 5'd0) && ((we_EX  && rd_num_EX  == rs) ||
                                     (we_MEM && rd_num_MEM == rs) ||
                                     (we_WB  && rd_num_WB  == rs));
    assign hit_rt = (rt != 5'd0) && ((we_EX  && rd_num_EX  == rt) ||
                                     (we_MEM && rd_num_MEM == rt) ||
                                     (we_WB  && rd_num_WB  == rt));
    assign raw        = hit_rs || (uses_rt_ID && hit_rt);
    assign syscall_ID = (inst_ID[31:26] == 6'd0) && (inst_ID[5:0] == 6'h0C);
    assign miss       = mem_access_MEM && !cache_ready;

    always_comb begin
        // NOTE: every output and next-state value gets a default so no path infers a latch.
        pc_we       = 1'b0;
        hold_ifid   = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_exmem = 1'b0;
        freeze_all  = 1'b0;
        next_state  = state;
        next_drain  = drain_cnt;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (state == HALTED) begin
            freeze_all = 1'b1;
        end else if (miss) begin
            // A miss while draining keeps DRAIN with the drain counter frozen.
            freeze_all = 1'b1;
            stall_inc  = 1'b1;
            next_state = (state == DRAIN) ? DRAIN : MEM_WAIT;
        end else if (redirect_MEM) begin
            pc_we       = 1'b1;
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            flush_exmem = 1'b1;
            flush_inc   = 1'b1;
            next_state  = RUN;
        end else if (state == DRAIN) begin
            hold_ifid   = 1'b1;
            bubble_idex = 1'b1;
            if (drain_cnt == '0) next_state = HALTED;
            else                 next_drain = drain_cnt - 1'b1;
        end else if (syscall_ID) begin
            hold_ifid   = 1'b1;
            bubble_idex = 1'b1;
            next_state  = DRAIN;
            next_drain  = DW'(DRAIN_CYC - 1);
        end else if (raw) begin
            hold_ifid   = 1'b1;
            bubble_idex = 1'b1;
            stall_inc   = 1'b1;
            next_state  = RUN;
        end else begin
            pc_we      = 1'b1;
            next_state = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state       <= RUN;
            drain_cnt   <= '0;
            halted      <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state     <= next_state;
            drain_cnt <= next_drain;
            halted    <= (next_state == HALTED);
            if (stall_inc && stall_count != '1) stall_count <= stall_count + 1'b1;
            if (flush_inc && flush_count != '1) flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random traffic
// compared against a behavioural model of the controller rules.
module tb_pipeline_ctrl;

    localparam int TB_CNT_W = 4;
    localparam int TB_DRAIN = 3;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_b = 1'b0;
    logic [31:0]         inst_ID = '0;
    logic                uses_rt_ID = 1'b0;
    logic [4:0]          rd_num_EX = '0, rd_num_MEM = '0, rd_num_WB = '0;
    logic                we_EX = 1'b0, we_MEM = 1'b0, we_WB = 1'b0;
    logic                redirect_MEM = 1'b0, mem_access_MEM = 1'b0, cache_ready = 1'b1;
    logic                pc_we, hold_ifid, flush_ifid, bubble_idex, flush_exmem, freeze_all, halted;
    logic [TB_CNT_W-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    pipeline_ctrl #(.CNT_W(TB_CNT_W), .DRAIN_CYC(TB_DRAIN)) dut (
        .clk(clk), .rst_b(rst_b), .inst_ID(inst_ID), .uses_rt_ID(uses_rt_ID),
        .rd_num_EX(rd_num_EX), .rd_num_MEM(rd_num_MEM), .rd_num_WB(rd_num_WB),
        .we_EX(we_EX), .we_MEM(we_MEM), .we_WB(we_WB),
        .redirect_MEM(redirect_MEM), .mem_access_MEM(mem_access_MEM), .cache_ready(cache_ready),
        .pc_we(pc_we), .hold_ifid(hold_ifid), .flush_ifid(flush_ifid), .bubble_idex(bubble_idex),
        .flush_exmem(flush_exmem), .freeze_all(freeze_all), .halted(halted),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_halted, m_draining;
    int m_drain_left, m_stall, m_flush;
    // expected controls, packed as {pc_we, hold, flush_ifid, bubble, flush_exmem, freeze}
    logic [5:0] e_ctl;

    function automatic logic [31:0] i_type(input logic [4:0] s, input logic [4:0] t);
        return {6'h08, s, t, 16'h0010};
    endfunction

    function automatic logic [31:0] syscall_inst();
        return {6'd0, 20'd0, 6'h0C};
    endfunction

    function automatic bit reads_busy_reg();
        logic [4:0] dst[3];
        bit         wr[3];
        bit         busy = 0;
        dst = '{rd_num_EX, rd_num_MEM, rd_num_WB};
        wr  = '{we_EX, we_MEM, we_WB};
        for (int s = 0; s < 3; s++) begin
            if (wr[s] && dst[s] != 0 && dst[s] == inst_ID[25:21]) busy = 1;
            if (wr[s] && uses_rt_ID && dst[s] != 0 && dst[s] == inst_ID[20:16]) busy = 1;
        end
        return busy;
    endfunction

    function automatic bit is_syscall();
        return inst_ID[31:26] == 0 && inst_ID[5:0] == 6'h0C;
    endfunction

    task automatic model_eval();
        bit miss = mem_access_MEM && !cache_ready;
        if (m_halted || miss)                  e_ctl = 6'b000001;
        else if (redirect_MEM)                 e_ctl = 6'b101110;
        else if (m_draining || is_syscall())   e_ctl = 6'b010100;
        else if (reads_busy_reg())             e_ctl = 6'b010100;
        else                                   e_ctl = 6'b100000;
    endtask

    task automatic model_tick();
        bit miss = mem_access_MEM && !cache_ready;
        if (!rst_b) begin
            m_halted = 0; m_draining = 0; m_drain_left = 0; m_stall = 0; m_flush = 0;
        end else if (m_halted) begin
        end else if (miss) begin
            m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
        end else if (redirect_MEM) begin
            m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
            m_draining = 0;
        end else if (m_draining) begin
            m_drain_left--;
            if (m_drain_left == 0) begin
                m_halted = 1;
                m_draining = 0;
            end
        end else if (is_syscall()) begin
            m_draining = 1;
            m_drain_left = TB_DRAIN;
        end else if (reads_busy_reg()) begin
            m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
        end
    endtask

    // ---------------- sequencing helpers ----------------
    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic set_idle();
        inst_ID = '0; uses_rt_ID = 0;
        rd_num_EX = '0; rd_num_MEM = '0; rd_num_WB = '0;
        we_EX = 0; we_MEM = 0; we_WB = 0;
        redirect_MEM = 0; mem_access_MEM = 0; cache_ready = 1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_b = 0;
        advance();
        advance();
        rst_b = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        inst_ID = syscall_inst();
        for (int k = 0; k < 4; k++) advance();
        settle();
        total++;
        if (halted !== 1'b1) begin bad++; $display("FAIL reset_pre_halted: got %b want 1", halted); end
        rst_b = 0;
        advance();
        advance();
        settle();
        total++;
        if (halted !== 1'b0 || stall_count !== '0 || flush_count !== '0) begin
            bad++;
            $display("FAIL reset_regs: halted=%b stall=%0d flush=%0d want 0/0/0", halted, stall_count, flush_count);
        end
        rst_b = 1;
        set_idle();
        settle();
        total++;
        if (pc_we !== 1'b1 || freeze_all !== 1'b0 || hold_ifid !== 1'b0) begin
            bad++;
            $display("FAIL reset_run: pc_we=%b freeze=%b hold=%b want 1/0/0", pc_we, freeze_all, hold_ifid);
        end
        advance();
    endtask

    task automatic test_raw();
        do_reset();
        inst_ID = i_type(5'd5, 5'd6);
        for (int k = 0; k < 3; k++) begin
            we_EX = (k == 0); we_MEM = (k == 1); we_WB = (k == 2);
            rd_num_EX = 5'd5; rd_num_MEM = 5'd5; rd_num_WB = 5'd5;
            settle();
            total++;
            if ({pc_we, hold_ifid, bubble_idex} !== 3'b011) begin
                bad++;
                $display("FAIL raw_stall[%0d]: pc_we/hold/bubble=%b want 011", k, {pc_we, hold_ifid, bubble_idex});
            end
            advance();
        end
        we_EX = 0; we_MEM = 0; we_WB = 0;
        settle();
        total++;
        if (pc_we !== 1'b1 || hold_ifid !== 1'b0 || stall_count !== 4'd3) begin
            bad++;
            $display("FAIL raw_resume: pc_we=%b hold=%b stall=%0d want 1/0/3", pc_we, hold_ifid, stall_count);
        end
        advance();
    endtask

    task automatic test_miss();
        do_reset();
        mem_access_MEM = 1;
        for (int k = 0; k < 5; k++) begin
            cache_ready = (k == 4);
            settle();
            total++;
            if (freeze_all !== (k < 4) || pc_we !== (k == 4)) begin
                bad++;
                $display("FAIL miss_freeze[%0d]: freeze=%b pc_we=%b want %b/%b", k, freeze_all, pc_we, k < 4, k == 4);
            end
            advance();
        end
        mem_access_MEM = 0;
        settle();
        total++;
        if (stall_count !== 4'd4) begin bad++; $display("FAIL miss_count: got %0d want 4", stall_count); end
    endtask

    task automatic test_redirect_raw();
        do_reset();
        inst_ID = i_type(5'd5, 5'd0);
        we_EX = 1; rd_num_EX = 5'd5;
        redirect_MEM = 1;
        settle();
        total++;
        if ({pc_we, hold_ifid, flush_ifid, bubble_idex, flush_exmem, freeze_all} !== 6'b101110) begin
            bad++;
            $display("FAIL redirect_ctl: got %b want 101110",
                     {pc_we, hold_ifid, flush_ifid, bubble_idex, flush_exmem, freeze_all});
        end
        advance();
        set_idle();
        settle();
        total++;
        if (flush_count !== 4'd1 || stall_count !== 4'd0) begin
            bad++;
            $display("FAIL redirect_count: flush=%0d stall=%0d want 1/0", flush_count, stall_count);
        end
        advance();
    endtask

    task automatic test_halt();
        do_reset();
        inst_ID = syscall_inst();
        settle();
        total++;
        if ({pc_we, hold_ifid, bubble_idex} !== 3'b011) begin
            bad++;
            $display("FAIL halt_entry: pc_we/hold/bubble=%b want 011", {pc_we, hold_ifid, bubble_idex});
        end
        for (int e = 1; e <= 5; e++) begin
            advance();
            settle();
            total++;
            if (halted !== (e >= 4)) begin
                bad++;
                $display("FAIL halt_edge[%0d]: halted=%b want %b", e, halted, e >= 4);
            end
        end
        total++;
        if (freeze_all !== 1'b1 || pc_we !== 1'b0) begin
            bad++;
            $display("FAIL halt_freeze: freeze=%b pc_we=%b want 1/0", freeze_all, pc_we);
        end

        do_reset();
        inst_ID = syscall_inst();
        advance();
        advance();
        redirect_MEM = 1;
        settle();
        total++;
        if (pc_we !== 1'b1 || flush_exmem !== 1'b1) begin
            bad++;
            $display("FAIL halt_cancel_ctl: pc_we=%b flush_exmem=%b want 1/1", pc_we, flush_exmem);
        end
        advance();
        set_idle();
        for (int k = 0; k < 5; k++) begin
            settle();
            total++;
            if (halted !== 1'b0 || pc_we !== 1'b1) begin
                bad++;
                $display("FAIL halt_cancel[%0d]: halted=%b pc_we=%b want 0/1", k, halted, pc_we);
            end
            advance();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_access_MEM = 1; cache_ready = 0;
        for (int k = 0; k <= 20; k++) begin
            settle();
            total++;
            if (stall_count !== TB_CNT_W'((k < CNT_MAX) ? k : CNT_MAX)) begin
                bad++;
                $display("FAIL sat_stall[%0d]: got %0d want %0d", k, stall_count, (k < CNT_MAX) ? k : CNT_MAX);
            end
            if (k < 20) advance();
        end
        set_idle();
        advance();
    endtask

    task automatic test_random();
        int halted_run = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_b = ($urandom_range(0, 149) != 0) && (halted_run < 4);
            if (m_halted) halted_run++; else halted_run = 0;
            inst_ID = ($urandom_range(0, 14) == 0) ? syscall_inst()
                      : i_type(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            uses_rt_ID     = 1'($urandom);
            rd_num_EX      = 5'($urandom_range(0, 3));
            rd_num_MEM     = 5'($urandom_range(0, 3));
            rd_num_WB      = 5'($urandom_range(0, 3));
            we_EX          = ($urandom_range(0, 2) == 0);
            we_MEM         = ($urandom_range(0, 2) == 0);
            we_WB          = ($urandom_range(0, 2) == 0);
            redirect_MEM   = ($urandom_range(0, 9) == 0);
            mem_access_MEM = ($urandom_range(0, 2) == 0);
            cache_ready    = 1'($urandom);
            settle();
            if (rst_b) begin
                total++;
                if ({pc_we, hold_ifid, flush_ifid, bubble_idex, flush_exmem, freeze_all} !== e_ctl) begin
                    bad++;
                    $display("FAIL rand_ctl[%0d]: got %b want %b", n,
                             {pc_we, hold_ifid, flush_ifid, bubble_idex, flush_exmem, freeze_all}, e_ctl);
                end
            end
            total++;
            if (halted !== m_halted || stall_count !== TB_CNT_W'(m_stall) || flush_count !== TB_CNT_W'(m_flush)) begin
                bad++;
                $display("FAIL rand_regs[%0d]: halted=%b stall=%0d flush=%0d want %b/%0d/%0d",
                         n, halted, stall_count, flush_count, m_halted, m_stall, m_flush);
            end
            advance();
        end
        rst_b = 1;
    endtask

    initial begin
        test_reset();
        test_raw();
        test_miss();
        test_redirect_raw();
        test_halt();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
